// File: rtl/mul_div_unit_if.sv
// Bus between the EX stage and the iterative multiply/divide unit.
// master: EX-stage issue/MT-write side; slave: the mul_div_unit itself.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, in1, in2, hi_we, lo_we, wdata,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, in1, in2, hi_we, lo_we, wdata,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per cycle.
// Define MDU_DIV_EN to build the divide datapath; without it, ops 10/11 are
// not accepted and div_zero stays 0.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted
// CALC  | WIDTH iterations of shift-add or restoring divide
// FIX   | sign correction, HI/LO write, done pulse
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  mdu
);
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic               accept, in1_neg, in2_neg;
    logic [WIDTH-1:0]   in1_mag, in2_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept  = mdu.start && (DIV_EN || !mdu.op[1]);
    assign in1_neg = !mdu.op[0] && mdu.in1[WIDTH-1];
    assign in2_neg = !mdu.op[0] && mdu.in2[WIDTH-1];
    assign in1_mag = in1_neg ? -mdu.in1 : mdu.in1;
    assign in2_mag = in2_neg ? -mdu.in2 : mdu.in2;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient}; the shifted
    // remainder needs one extra bit, the stored one never exceeds the divisor.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_q};
    assign div_ge    = !div_diff[WIDTH];
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};

    // With a zero divisor the remainder simply accumulates the dividend
    // magnitude, so re-applying in1's sign reproduces in1 for HI.
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Next-state, datapath and HI/LO update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        b_d       = b_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d   = S_CALC;
                    cnt_d     = CW'(WIDTH);
                    is_div_d  = mdu.op[1];
                    neg_d     = in1_neg ^ in2_neg;
                    neg_rem_d = in1_neg;
                    b_d       = in2_mag;
                    acc_d     = {{WIDTH{1'b0}}, in1_mag};
                end else begin
                    if (mdu.hi_we) hi_d = mdu.wdata;
                    if (mdu.lo_we) lo_d = mdu.wdata;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIX;
                acc_d = (DIV_EN && is_div_q) ? div_next : mul_next;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (DIV_EN && is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = (b_q == '0) ? '1 : quo_fix;
                    dz_d = (b_q == '0);
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and result registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign mdu.busy     = busy_q;
    assign mdu.done     = done_q;
    assign mdu.div_zero = dz_q;
    assign mdu.hi       = hi_q;
    assign mdu.lo       = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit (WIDTH=32). Divide vectors are used when
// MDU_DIV_EN is defined; otherwise divide issues must be ignored.
module tb_mul_div_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(W)) mdu_if ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu_if.slave)
    );

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pops one expected result; div_zero must be low otherwise.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && mdu_if.done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    e = sb_q.pop_front();
                    chk("result_hi", 64'(mdu_if.hi), 64'(e.hi));
                    chk("result_lo", 64'(mdu_if.lo), 64'(e.lo));
                    chk("result_dz", 64'(mdu_if.div_zero), 64'(e.dz));
                end
            end else if (!reset) begin
                chk("dz_without_done", 64'(mdu_if.div_zero), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Issue one op; returns at E0+#1 with start dropped.
    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.dz = edz;
        sb_q.push_back(e);
        mdu_if.start = 1'b1;
        mdu_if.op    = o;
        mdu_if.in1   = a;
        mdu_if.in2   = b;
        @(posedge clk);
        #1;
        mdu_if.start = 1'b0;
    endtask

    // Wait for done from E0+#1; checks latency, busy length and HI/LO stability.
    task automatic wait_done(input string name);
        int n = 0;
        int bc = 0;
        bit stable = 1'b1;
        logic [W-1:0] h0 = mdu_if.hi;
        logic [W-1:0] l0 = mdu_if.lo;
        while (!mdu_if.done && n < 200) begin
            if (mdu_if.busy) bc++;
            if (mdu_if.hi !== h0 || mdu_if.lo !== l0) stable = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(W + 1));
        chk({name, "_busy_cycles"}, 64'(bc), 64'(W + 1));
        chk({name, "_hilo_stable"}, 64'(stable), 64'd1);
        chk({name, "_busy_at_done"}, 64'(mdu_if.busy), 64'd0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int dc;
        logic [W-1:0] h_prev, l_prev;
        mdu_if.start = 1'b0;
        mdu_if.op    = 2'b00;
        mdu_if.in1   = '0;
        mdu_if.in2   = '0;
        mdu_if.hi_we = 1'b0;
        mdu_if.lo_we = 1'b0;
        mdu_if.wdata = '0;
        tick(3);
        reset = 1'b0;
        chk("reset_busy", 64'(mdu_if.busy), 64'd0);
        chk("reset_done", 64'(mdu_if.done), 64'd0);
        chk("reset_hi", 64'(mdu_if.hi), 64'd0);
        chk("reset_lo", 64'(mdu_if.lo), 64'd0);
        tick(1);

        // MULTU max x max, then MULT -3 x 7 issued in the done cycle.
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_done("multu_max");
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        wait_done("mult_neg");
        tick(1);

`ifdef MDU_DIV_EN
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        wait_done("div_ovf");
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done("div_neg");
        start_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_done("divu");
        start_op(2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
        wait_done("divu_zero");
        start_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        wait_done("div_zero_signed");
        tick(1);
`else
        h_prev = mdu_if.hi;
        l_prev = mdu_if.lo;
        dc = done_cnt;
        mdu_if.start = 1'b1; mdu_if.op = 2'b11; mdu_if.in1 = 32'd100; mdu_if.in2 = 32'd7;
        tick(1);
        mdu_if.start = 1'b0;
        chk("div_off_busy", 64'(mdu_if.busy), 64'd0);
        tick(40);
        chk("div_off_no_done", 64'(done_cnt), 64'(dc));
        chk("div_off_hi", 64'(mdu_if.hi), 64'(h_prev));
        chk("div_off_lo", 64'(mdu_if.lo), 64'(l_prev));
`endif

        // MT writes in IDLE.
        mdu_if.hi_we = 1'b1; mdu_if.wdata = 32'h1234_5678;
        tick(1);
        mdu_if.hi_we = 1'b0;
        chk("mthi", 64'(mdu_if.hi), 64'h1234_5678);
        mdu_if.lo_we = 1'b1; mdu_if.wdata = 32'hCAFE_BABE;
        tick(1);
        mdu_if.lo_we = 1'b0;
        chk("mtlo", 64'(mdu_if.lo), 64'hCAFE_BABE);
        chk("mtlo_hi_kept", 64'(mdu_if.hi), 64'h1234_5678);
        mdu_if.hi_we = 1'b1; mdu_if.lo_we = 1'b1; mdu_if.wdata = 32'hA5A5_A5A5;
        tick(1);
        mdu_if.hi_we = 1'b0; mdu_if.lo_we = 1'b0;
        chk("mt_both_hi", 64'(mdu_if.hi), 64'hA5A5_A5A5);
        chk("mt_both_lo", 64'(mdu_if.lo), 64'hA5A5_A5A5);

        // start and MTHI in the same cycle: start wins.
        mdu_if.hi_we = 1'b1; mdu_if.wdata = 32'h1111_1111;
        start_op(2'b01, 32'd7, 32'd7, 32'd0, 32'd49, 1'b0);
        mdu_if.hi_we = 1'b0;
        chk("start_beats_mt", 64'(mdu_if.hi), 64'hA5A5_A5A5);
        wait_done("start_mt");

        // MTLO during busy is dropped.
        start_op(2'b00, 32'd5, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b0);
        fork
            begin
                tick(3);
                mdu_if.lo_we = 1'b1; mdu_if.wdata = 32'hDEAD_BEEF;
                tick(4);
                mdu_if.lo_we = 1'b0;
            end
        join_none
        wait_done("mtlo_busy");

        // Second start while busy is ignored: one done only.
        dc = done_cnt;
        start_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
        fork
            begin
                tick(5);
                mdu_if.start = 1'b1; mdu_if.op = 2'b01; mdu_if.in1 = 32'd9; mdu_if.in2 = 32'd9;
                tick(1);
                mdu_if.start = 1'b0;
            end
        join_none
        wait_done("start_busy");
        tick(40);
        chk("single_done", 64'(done_cnt - dc), 64'd1);
        chk("idle_after_ignored_start", 64'(mdu_if.busy), 64'd0);

        // Reset in CALC cycle 10 discards the operation.
        start_op(2'b01, 32'd123, 32'd456, 32'd0, 32'd56088, 1'b0);
        tick(9);
        reset = 1'b1;
        void'(sb_q.pop_back());
        dc = done_cnt;
        tick(1);
        reset = 1'b0;
        chk("rst_mid_busy", 64'(mdu_if.busy), 64'd0);
        chk("rst_mid_done", 64'(mdu_if.done), 64'd0);
        chk("rst_mid_hi", 64'(mdu_if.hi), 64'd0);
        chk("rst_mid_lo", 64'(mdu_if.lo), 64'd0);
        tick(40);
        chk("rst_no_done", 64'(done_cnt), 64'(dc));
        start_op(2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);
        wait_done("after_reset");
        tick(2);

        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
